// File: rtl/ntt_result_pingpong_if.sv
// Beat stream between the NTT result path and the ping-pong buffer / DMA.
// Each bundle carries one 64-bit beat and its valid/ready handshake.
interface ntt_result_pingpong_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/ntt_result_pingpong.sv
// Two-bank ping-pong buffer for NTT result polynomials: the core fills one bank
// while the DMA drains the other; also flags bad packet lengths and counts output polys.
module ntt_result_pingpong #(
  parameter int unsigned BEATS = 128
) (
  input  logic                  clk,
  input  logic                  areset,
  ntt_result_pingpong_if.slave  s_axis,
  ntt_result_pingpong_if.master m_axis,
  input  logic                  err_clr,
  output logic                  err_short,
  output logic                  err_long,
  output logic [7:0]            poly_cnt
);

  localparam int unsigned   CW   = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic          wr_bank;
  logic [CW-1:0] wr_cnt;
  logic          rd_bank;
  logic [CW-1:0] rd_cnt;
  logic          iss_done;

  logic [45:0]   mem [2][BEATS];
  logic [45:0]   rd_data;
  logic          p_valid;
  logic          p_last;

  logic [45:0]   sk0_data;
  logic [45:0]   sk1_data;
  logic          sk0_last;
  logic          sk1_last;
  logic [1:0]    sk_cnt;

  logic          s_hs;
  logic          s_long;
  logic          s_short;
  logic          rd_en;
  logic          m_hs;
  logic          m_last_hs;
  logic          out_valid;
  logic          out_last;
  logic [45:0]   out_data;
  logic          unused_bits;

  assign unused_bits = ^{s_axis.tkeep, s_axis.tdata[63:55], s_axis.tdata[31:23]};

  assign s_hs      = s_axis.tvalid && s_axis.tready;
  assign s_long    = s_hs && (wr_cnt == LAST) && !s_axis.tlast;
  assign s_short   = s_hs && (wr_cnt != LAST) && s_axis.tlast;
  assign m_hs      = out_valid && m_axis.tready;
  assign m_last_hs = m_hs && out_last;

  // Reads run ahead of the consumer; at most two beats may be held or in flight
  // (skid + RAM output stage), so a full stall never drops a beat.
  assign rd_en = ((bank_q[rd_bank] == FULL) || (bank_q[rd_bank] == DRAINING)) && !iss_done &&
                 ((sk_cnt == 2'd0) || ((sk_cnt == 2'd1) && !p_valid));

  // Bank state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Bank next-state: writer touches only wr_bank (EMPTY/FILLING), reader only
  // rd_bank (FULL/DRAINING), so the two updates never collide.
  always_comb begin
    bank_d = bank_q;
    if (s_hs) begin
      if (wr_cnt == LAST)        bank_d[wr_bank] = FULL;
      else if (s_axis.tlast)     bank_d[wr_bank] = EMPTY;
      else                       bank_d[wr_bank] = FILLING;
    end
    if (rd_en && (bank_q[rd_bank] == FULL)) bank_d[rd_bank] = DRAINING;
    if (m_last_hs)                          bank_d[rd_bank] = EMPTY;
  end

  // Outputs
  always_comb begin
    s_axis.tready = (bank_q[wr_bank] == EMPTY) || (bank_q[wr_bank] == FILLING);
    if (sk_cnt != 2'd0) begin
      out_valid = 1'b1;
      out_data  = sk0_data;
      out_last  = sk0_last;
    end else begin
      out_valid = p_valid;
      out_data  = rd_data;
      out_last  = p_last;
    end
    m_axis.tvalid = out_valid;
    m_axis.tdata  = out_valid ? {9'b0, out_data[45:23], 9'b0, out_data[22:0]} : '0;
    m_axis.tlast  = out_valid && out_last;
    m_axis.tkeep  = '1;
  end

  // Write pointer and sticky error flags
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (s_hs) begin
        if (wr_cnt == LAST) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else if (s_axis.tlast) begin
          wr_cnt  <= '0;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      err_short <= s_short || (err_short && !err_clr);
      err_long  <= s_long  || (err_long  && !err_clr);
    end
  end

  // Coefficient storage, synchronous read
  always_ff @(posedge clk) begin
    if (s_hs)  mem[wr_bank][wr_cnt] <= {s_axis.tdata[54:32], s_axis.tdata[22:0]};
    if (rd_en) rd_data <= mem[rd_bank][rd_cnt];
  end

  // Read pointer, RAM output stage, skid buffer and delivered-poly counter
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      iss_done <= 1'b0;
      p_valid  <= 1'b0;
      p_last   <= 1'b0;
      sk_cnt   <= 2'd0;
      sk0_data <= '0;
      sk1_data <= '0;
      sk0_last <= 1'b0;
      sk1_last <= 1'b0;
      poly_cnt <= '0;
    end else begin
      p_valid <= rd_en;
      if (rd_en) begin
        p_last <= (rd_cnt == LAST);
        if (rd_cnt == LAST) begin
          rd_cnt   <= '0;
          iss_done <= 1'b1;
        end else begin
          rd_cnt   <= rd_cnt + 1'b1;
        end
      end
      if (m_last_hs) begin
        rd_bank  <= ~rd_bank;
        iss_done <= 1'b0;
        poly_cnt <= poly_cnt + 8'd1;
      end
      // Skid head feeds the output; the RAM stage bypasses it when it is empty
      case (sk_cnt)
        2'd0: begin
          if (p_valid && !m_hs) begin
            sk0_data <= rd_data;
            sk0_last <= p_last;
            sk_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (m_hs) begin
            if (p_valid) begin
              sk0_data <= rd_data;
              sk0_last <= p_last;
            end else begin
              sk_cnt   <= 2'd0;
            end
          end else if (p_valid) begin
            sk1_data <= rd_data;
            sk1_last <= p_last;
            sk_cnt   <= 2'd2;
          end
        end
        default: begin
          if (m_hs) begin
            sk0_data <= sk1_data;
            sk0_last <= sk1_last;
            sk_cnt   <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_result_pingpong.sv
// Directed bench for ntt_result_pingpong: streams polynomials in, scoreboards the
// output beats against a queue of expected beats, and checks flags and counters.
module tb_ntt_result_pingpong;

  localparam int BEATS = 128;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
  } beat_t;

  logic       clk;
  logic       areset;
  logic       err_clr;
  logic       err_short;
  logic       err_long;
  logic [7:0] poly_cnt;

  ntt_result_pingpong_if s_if ();
  ntt_result_pingpong_if m_if ();

  ntt_result_pingpong #(.BEATS(BEATS)) dut (
    .clk       (clk),
    .areset    (areset),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .err_clr   (err_clr),
    .err_short (err_short),
    .err_long  (err_long),
    .poly_cnt  (poly_cnt)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          beat_idx = 0;
  int          first_cyc = 0;
  int          span = -1;
  bit          bp_mode = 1'b0;
  beat_t       exp_q [$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat_in(input int p, input int k);
    logic [22:0] ev, od;
    ev = 23'(p * 512 + 2 * k);
    od = 23'(p * 512 + 2 * k + 1);
    return {9'h100 | 9'(k * 37 + p), od, 9'h100 | 9'(k * 11 + 3), ev};
  endfunction

  function automatic logic [63:0] beat_out(input int p, input int k);
    logic [22:0] ev, od;
    ev = 23'(p * 512 + 2 * k);
    od = 23'(p * 512 + 2 * k + 1);
    return {9'b0, od, 9'b0, ev};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Output monitor: handshakes are decided by values seen at the falling edge
  initial forever begin
    @(negedge clk);
    if (areset) begin
      exp_q.delete();
      beat_idx   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("m_hold", {m_if.tvalid, m_if.tlast, m_if.tdata[61:0]},
              {1'b1, prev_last, prev_data[61:0]});
      if (m_if.tvalid && m_if.tready) begin
        check("m_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("m_data", m_if.tdata, e.d);
          check("m_last", 64'(m_if.tlast), 64'(e.last));
        end
        if (beat_idx == 0) first_cyc = cyc;
        beat_idx++;
        if (m_if.tlast) begin
          span     = cyc - first_cyc;
          beat_idx = 0;
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  task automatic send_poly(input int p, input int nbeats, input int last_at,
                           input bit clr_on_last, output int stalls);
    int guard;
    stalls = 0;
    if (nbeats == BEATS)
      for (int k = 0; k < BEATS; k++) exp_q.push_back('{d: beat_out(p, k), last: (k == BEATS - 1)});
    for (int k = 0; k < nbeats; k++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = beat_in(p, k);
      s_if.tlast  = (k == last_at);
      err_clr     = clr_on_last && (k == nbeats - 1);
      guard = 0;
      while (!s_if.tready && guard < 5000) begin
        @(posedge clk);
        #1;
        guard++;
        stalls++;
      end
      if (guard >= 5000) begin
        check("s_ready_timeout", 64'(s_if.tready), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    err_clr     = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !m_if.tvalid) break;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    areset      = 1'b1;
    err_clr     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = 8'hFF;
    s_if.tlast  = 1'b0;
    #3;
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata",  m_if.tdata, 64'd0);
    check("rst_m_tlast",  64'(m_if.tlast), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd1);
    check("rst_err_short", 64'(err_short), 64'd0);
    check("rst_err_long", 64'(err_long), 64'd0);
    check("rst_poly_cnt", 64'(poly_cnt), 64'd0);
    check("m_tkeep", 64'(m_if.tkeep), 64'hFF);
    #20 areset = 1'b0;
    @(posedge clk);
    #1;

    // Single polynomial: latency 2 from commit, 128 contiguous beats
    send_poly(0, BEATS, BEATS - 1, 1'b0, st);
    check("t1_valid_at_T1", 64'(m_if.tvalid), 64'd0);
    check("t1_sready_at_T1", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    #1;
    check("t1_valid_at_T2", 64'(m_if.tvalid), 64'd1);
    check("t1_first_beat", m_if.tdata, beat_out(0, 0));
    wait_drain("t1_drain");
    check("t1_span", 64'(span), 64'd127);
    check("t1_poly_cnt", 64'(poly_cnt), 64'd1);

    // Overlap: three back-to-back polys
    send_poly(1, BEATS, BEATS - 1, 1'b0, st);
    check("ovl_p0_stalls", 64'(st), 64'd0);
    send_poly(2, BEATS, BEATS - 1, 1'b0, st);
    check("ovl_p1_stalls", 64'(st), 64'd0);
    send_poly(3, BEATS, BEATS - 1, 1'b0, st);
    check("ovl_p2_stalled", 64'(st != 0), 64'd1);
    wait_drain("ovl_drain");
    check("ovl_span", 64'(span), 64'd127);
    check("ovl_poly_cnt", 64'(poly_cnt), 64'd4);

    // Back-pressure: ~30% ready duty
    bp_mode = 1'b1;
    for (int p = 4; p < 8; p++) send_poly(p, BEATS, BEATS - 1, 1'b0, st);
    wait_drain("bp_drain");
    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    check("bp_poly_cnt", 64'(poly_cnt), 64'd8);

    // Short packet: tlast on beat 50 is discarded and flagged
    send_poly(20, 51, 50, 1'b0, st);
    repeat (5) @(posedge clk);
    #1;
    check("short_err_short", 64'(err_short), 64'd1);
    check("short_err_long", 64'(err_long), 64'd0);
    check("short_no_output", 64'(m_if.tvalid), 64'd0);
    check("short_sready", 64'(s_if.tready), 64'd1);
    send_poly(21, BEATS, BEATS - 1, 1'b0, st);
    wait_drain("short_next_drain");
    check("short_poly_cnt", 64'(poly_cnt), 64'd9);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("short_cleared", 64'(err_short), 64'd0);

    // Missing tlast, with err_clr coinciding with the error event
    send_poly(30, BEATS, -1, 1'b1, st);
    check("long_err_long", 64'(err_long), 64'd1);
    check("long_err_short", 64'(err_short), 64'd0);
    wait_drain("long_drain");
    check("long_poly_cnt", 64'(poly_cnt), 64'd10);

    // Reset while beat 60 of the output is presented
    send_poly(40, BEATS, BEATS - 1, 1'b0, st);
    for (int i = 0; i < 1000; i++) begin
      if (beat_idx == 61) break;
      @(negedge clk);
      #1;
    end
    check("rst_reach_beat60", 64'(beat_idx), 64'd61);
    #1 areset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_m_tdata", m_if.tdata, 64'd0);
    check("mid_rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("mid_rst_s_tready", 64'(s_if.tready), 64'd1);
    check("mid_rst_err_long", 64'(err_long), 64'd0);
    check("mid_rst_poly_cnt", 64'(poly_cnt), 64'd0);
    @(negedge clk);
    #2 areset = 1'b0;
    @(posedge clk);
    #1;
    send_poly(41, BEATS, BEATS - 1, 1'b0, st);
    check("post_rst_stalls", 64'(st), 64'd0);
    wait_drain("post_rst_drain");
    check("post_rst_span", 64'(span), 64'd127);
    check("post_rst_poly_cnt", 64'(poly_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
